relu_maxpool2x2: RTL and testbench

RELU_MAXPOOL2X2 -- requirements
Module: relu_maxpool2x2

---
 rtl/relu_maxpool2x2.sv | 115 +++++++++++
 tb/tb_relu_maxpool2x2.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/relu_maxpool2x2.sv
// Bias + saturating ReLU on a raster pixel stream, followed by 2x2 max pooling.
// A holding register pairs columns; a half-width line buffer pairs rows.
module relu_maxpool2x2 #(
  parameter int                            DATA_WIDTH = 24,
  parameter int                            IMG_WIDTH  = 10,
  parameter int                            IMG_HEIGHT = 10,
  parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int unsigned HALF_W = IMG_WIDTH / 2;
  localparam int          CW     = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int          RW     = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int          LW     = (HALF_W     > 1) ? $clog2(HALF_W)     : 1;
  localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] POS_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  vout_q, vout_d;
  logic                  fd_q, fd_d;
  logic [DATA_WIDTH-1:0] lb_q [HALF_W];

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] p, h, lb_rd, pool;
  logic [LW-1:0]         lb_idx;
  logic                  lb_we;

  // One extra bit keeps the true sign; a non-negative sum with the top data
  // bit set has overflowed and clamps to the positive maximum.
  assign sum = {data_in[DATA_WIDTH-1], data_in} + {BIAS[DATA_WIDTH-1], BIAS};

  always_comb begin
    if (sum[DATA_WIDTH])
      p = '0;
    else if (sum[DATA_WIDTH-1])
      p = POS_MAX;
    else
      p = sum[DATA_WIDTH-1:0];
  end

  assign h      = (p > hold_q) ? p : hold_q;
  assign lb_idx = LW'(col_q >> 1);
  assign lb_rd  = lb_q[lb_idx];
  assign pool   = (lb_rd > h) ? lb_rd : h;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    out_d  = out_q;
    vout_d = 1'b0;
    fd_d   = 1'b0;
    lb_we  = 1'b0;
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = p;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_d  = pool;
        vout_d = 1'b1;
        fd_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      out_q  <= '0;
      vout_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      out_q  <= out_d;
      vout_q <= vout_d;
      fd_q   <= fd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < HALF_W; i++)
        lb_q[i] <= '0;
    end else if (lb_we) begin
      lb_q[lb_idx] <= h;
    end
  end

  assign data_out   = out_q;
  assign valid_out  = vout_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench for relu_maxpool2x2 on a 4x4 frame; a second instance with a
// maximal bias runs in lockstep to exercise positive saturation.
module tb_relu_maxpool2x2;

  localparam int DW = 24;
  localparam logic [DW-1:0] SAT = 24'h7FFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_in2 = 24'd100;
  logic [DW-1:0] dout, dout2;
  logic          vo, vo2, fd, fd2;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_hold  = '0;
  logic [DW-1:0] exp_hold2 = '0;

  relu_maxpool2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .BIAS(24'sd0)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_out(dout), .valid_out(vo), .frame_done(fd)
  );

  relu_maxpool2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .BIAS(24'sh7FFFFF)) u_sat (
    .clk(clk), .rst(rst), .data_in(data_in2), .valid_in(valid_in),
    .data_out(dout2), .valid_out(vo2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] din;
    logic          vin;
    logic          ev;
    logic [DW-1:0] ed;
    logic          efd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int din, logic vin, logic ev, int ed, logic efd);
    vec_t v;
    v.din = DW'(din);
    v.vin = vin;
    v.ev  = ev;
    v.ed  = DW'(ed);
    v.efd = efd;
    return v;
  endfunction

  function automatic logic is_out(int k);
    return (k == 6) || (k == 8) || (k == 14) || (k == 16);
  endfunction

  task automatic check(string name, logic ev, logic [DW-1:0] ed, logic efd);
    tests++;
    if (ev) begin
      exp_hold  = ed;
      exp_hold2 = SAT;
    end
    if (vo !== ev || dout !== exp_hold || fd !== efd ||
        vo2 !== ev || dout2 !== exp_hold2 || fd2 !== efd) begin
      fails++;
      $display("FAIL %s: got v=%0b d=%0d fd=%0b sat_v=%0b sat_d=%0h sat_fd=%0b; expected v=%0b d=%0d fd=%0b sat_v=%0b sat_d=%0h sat_fd=%0b",
               name, vo, dout, fd, vo2, dout2, fd2, ev, exp_hold, efd, ev, exp_hold2, efd);
    end
  endtask

  task automatic pixel(string name, logic [DW-1:0] din, logic vin, logic ev, logic [DW-1:0] ed, logic efd);
    data_in  = din;
    valid_in = vin;
    @(posedge clk);
    #1;
    check(name, ev, ed, efd);
  endtask

  task automatic frame(string name, int sign);
    for (int k = 1; k <= 16; k++)
      pixel($sformatf("%s[%0d]", name, k), DW'(sign * k), 1'b1, is_out(k), (sign > 0) ? DW'(k) : '0, k == 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mix [16];
    int mix_exp [16];

    // Continuous 1..16 frame, then the same frame with a bubble after every pixel.
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(k, 1'b1, is_out(k), k, k == 16));
    for (int k = 1; k <= 16; k++) begin
      tbl.push_back(mk(k, 1'b1, is_out(k), k, k == 16));
      tbl.push_back(mk(777, 1'b0, 1'b0, 0, 1'b0));
    end

    mix = '{9, 1, 2, 20,  3, 4, 30, -5,  7, 50, 1, 45,  60, 8, 3, 40};
    mix_exp = '{0, 0, 0, 0, 0, 9, 0, 30, 0, 0, 0, 0, 0, 60, 0, 45};

    // Reset held with valid_in high: nothing may be consumed or emitted.
    rst = 1'b1;
    valid_in = 1'b1;
    data_in = DW'(55);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset", 1'b0, '0, 1'b0);
    end
    rst = 1'b0;

    foreach (tbl[i])
      pixel($sformatf("tbl[%0d]", i), tbl[i].din, tbl[i].vin, tbl[i].ev, tbl[i].ed, tbl[i].efd);

    frame("neg", -1);

    for (int k = 0; k < 16; k++)
      pixel($sformatf("mix[%0d]", k), DW'(mix[k]), 1'b1, is_out(k + 1), DW'(mix_exp[k]), k == 15);

    // Abort a frame after 9 pixels; the completed windows still emit.
    for (int k = 1; k <= 9; k++)
      pixel($sformatf("abort[%0d]", k), DW'(100 + k), 1'b1, is_out(k), DW'(100 + k), 1'b0);
    rst = 1'b1;
    data_in = DW'(999);
    exp_hold = '0;
    exp_hold2 = '0;
    #1;
    check("abort_rst_async", 1'b0, '0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_rst", 1'b0, '0, 1'b0);
    end
    rst = 1'b0;
    frame("post_abort", 1);

    frame("b2b_a", 1);
    frame("b2b_b", 1);

    valid_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_tail", 1'b0, '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
